byte_queue: RTL and testbench
=============================

Name: byte_queue

Overview:
- Receive-side byte FIFO directly downstream of the deserializer.
- Accepts each completed byte via the deserializer's data_ready/ack handshake and stores it in a circular buffer.
- Releases bytes to the consumer one per dequeue request and reports occupancy.
- Frees the deserializer for the next byte as soon as space exists.

Parameters:
- WIDTH, 8, bits per entry (matches the deserializer output byte).
- DEPTH, 8, number of entries; must be a power of two, ≥2.
- LEN_W, $clog2(DEPTH+1), width of the occupancy count (4 at the defaults).

Ports:
- clock_10KHZ  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; sampled only on the rising edge of clock_10KHZ.
- data_in  in  WIDTH  byte from the deserializer; valid while enqueue_in is high.
- enqueue_in  in  1  deserializer data_ready; level-held until acknowledged.
- ack_out  out  1  acknowledge to the deserializer ack_in.
- dequeue_in  in  1  consumer pop request; each high cycle is one pop attempt.
- data_out  out  WIDTH  last popped byte (registered).
- data_valid_out  out  1  one-cycle pulse: data_out was updated this cycle.
- len_out  out  LEN_W  current occupancy, 0..DEPTH.
- full_out  out  1  len_out == DEPTH.
- empty_out  out  1  len_out == 0.
- EA_queue  out  1  current handshake FSM state, for debug/LEDs.

Behaviour:
- Reset (synchronous, wins over every other input in that cycle):
  - ack_out=0, data_out=0, data_valid_out=0, len_out=0, full_out=0, empty_out=1.
  - Read and write pointers = 0; FSM = Q_IDLE.
  - Buffer contents are don't-care.
  - Reset mid-handshake drops ack_out and discards all stored bytes.
- Handshake FSM (states Q_IDLE=0, Q_ACK=1):
  - Q_IDLE, enqueue_in=1 and full_out=0: write data_in at wr_ptr, wr_ptr+1 (mod DEPTH), ack_out<=1, go to Q_ACK. Write latency 1 cycle.
  - Q_IDLE, enqueue_in=1 and full_out=1: no write, ack_out stays 0, stay in Q_IDLE. This backpressures the deserializer, which holds its byte.
  - Q_ACK: ack_out stays 1 until enqueue_in is sampled 0. Then ack_out<=0, go to Q_IDLE.
  - Exactly one write per data_ready assertion, regardless of how long the deserializer takes to drop it.
  - enqueue_in rising again in the same cycle ack_out falls is seen in Q_IDLE on the next cycle.
- Dequeue (independent of the FSM):
  - dequeue_in=1 and empty_out=0: data_out<=mem[rd_ptr], rd_ptr+1 (mod DEPTH), data_valid_out<=1 for that cycle. Latency 1 cycle.
  - dequeue_in=1 and empty_out=0 is evaluated on pre-edge state, so dequeue_in held high pops one byte per cycle until empty.
  - dequeue_in=1 and empty_out=1: ignored; data_out holds its value; data_valid_out=0.
- Simultaneous write and pop in one cycle: both occur; len_out is unchanged.
- Full and empty are judged on pre-edge state:
  - A write is refused when full, even if a pop happens in the same cycle.
  - A pop is refused when empty, even if a write happens in the same cycle.
- Occupancy and pointers:
  - len_out = len_out + write − pop; it never exceeds DEPTH and never underflows.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
  - full_out and empty_out are registered and derived from the next value of len_out, so they are coherent with len_out every cycle.
- No other timing paths from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package queue_pkg:
  - typedef enum logic {Q_IDLE, Q_ACK} queue_state_t
  - localparams QUEUE_WIDTH=8 and QUEUE_DEPTH=8
- Sub-module queue_storage:
  - DEPTH×WIDTH register array with a synchronous write port and a registered read port.
  - Pointers and occupancy stay in byte_queue.

Test Plan:
- Reset, then enqueue_in=1 with data_in=8'hA5 held 3 cycles, then 0 → single write; ack_out high from cycle 1 until the cycle after enqueue_in drops; len_out=1, empty_out=0.
- Enqueue 8'h01..8'h08 via full handshakes, then hold enqueue_in=1 with 8'h09 → full_out=1, len_out=8, ack_out stays 0; one dequeue → data_out=8'h01, next cycle 8'h09 accepted, len_out=8.
- Dequeue 8 bytes after wrap (second fill 8'h10..8'h17 after draining) → data_out sequence 8'h10..8'h17 with data_valid_out pulses; empty_out=1 afterwards.
- dequeue_in=1 while empty → data_valid_out=0, data_out unchanged, len_out=0.
- len_out=3, write 8'h55 and pop in the same cycle → len_out stays 3, popped byte is the oldest, 8'h55 comes out after two more pops.
- reset asserted while in Q_ACK with len_out=5 → next cycle ack_out=0, len_out=0, empty_out=1, EA_queue=0.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and default sizing for the receive byte queue.
// No logic, no latency, no flow control.
package queue_pkg;

    typedef enum logic {
        Q_IDLE = 1'b0,
        Q_ACK  = 1'b1
    } queue_state_t;

    localparam int QUEUE_WIDTH = 8;
    localparam int QUEUE_DEPTH = 8;

endpackage

// File: rtl/queue_storage.sv
// DEPTH x WIDTH register array: synchronous write, registered read (1 cycle).
// No backpressure; the caller guarantees only legal reads and writes.
module queue_storage
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/byte_queue.sv
// Receive byte FIFO behind the deserializer; write and pop each take effect 1 cycle later.
// Backpressure: ack_out is withheld while full, so the deserializer holds its byte.
module byte_queue
    import queue_pkg::*;
#(
    parameter int WIDTH = QUEUE_WIDTH,
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_10KHZ,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    output logic             ack_out,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    output logic [LEN_W-1:0] len_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             EA_queue
);

    localparam int PTR_W = $clog2(DEPTH);

    queue_state_t     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             full_q, empty_q;
    logic             dvalid_q;
    logic             wr_en;
    logic             rd_en;

    // One write per data_ready assertion: the write happens only on the IDLE->ACK step.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            Q_IDLE: begin
                if (enqueue_in && !full_q) begin
                    wr_en   = 1'b1;
                    state_d = Q_ACK;
                end
            end
            Q_ACK: begin
                if (!enqueue_in) begin
                    state_d = Q_IDLE;
                end
            end
            default: state_d = Q_IDLE;
        endcase
    end

    always_ff @(posedge clock_10KHZ) begin
        if (reset) begin
            state_q <= Q_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rd_en    = dequeue_in && !empty_q;
    assign wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    assign len_d    = len_q + LEN_W'(wr_en) - LEN_W'(rd_en);

    // Flags come from len_d so they stay coherent with len_out every cycle.
    always_ff @(posedge clock_10KHZ) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            full_q   <= (len_d == LEN_W'(DEPTH));
            empty_q  <= (len_d == '0);
            dvalid_q <= rd_en;
        end
    end

    queue_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_storage (
        .clk_i   (clock_10KHZ),
        .rst_i   (reset),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (data_out)
    );

    assign ack_out        = (state_q == Q_ACK);
    assign EA_queue       = state_q;
    assign data_valid_out = dvalid_q;
    assign len_out        = len_q;
    assign full_out       = full_q;
    assign empty_out      = empty_q;

endmodule

// File: tb/tb_byte_queue.sv
// Directed bench for byte_queue: handshake, full/empty boundaries, wrap, simultaneous push/pop, reset.
module tb_byte_queue;

    logic       clock_10KHZ = 1'b0;
    logic       reset       = 1'b1;
    logic [7:0] data_in     = 8'h00;
    logic       enqueue_in  = 1'b0;
    logic       dequeue_in  = 1'b0;
    logic       ack_out;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;
    logic       EA_queue;

    int tests = 0;
    int fails = 0;

    byte_queue dut (
        .clock_10KHZ    (clock_10KHZ),
        .reset          (reset),
        .data_in        (data_in),
        .enqueue_in     (enqueue_in),
        .ack_out        (ack_out),
        .dequeue_in     (dequeue_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .len_out        (len_out),
        .full_out       (full_out),
        .empty_out      (empty_out),
        .EA_queue       (EA_queue)
    );

    always #5 clock_10KHZ = ~clock_10KHZ;

    // Advance one rising edge and settle, so checks see that edge's result.
    task automatic tick();
        @(posedge clock_10KHZ);
        #1;
    endtask

    task automatic handshake(input logic [7:0] b);
        data_in    = b;
        enqueue_in = 1'b1;
        tick();
        enqueue_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests++; if (ack_out !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", ack_out); end
        tests++; if (len_out !== 4'd0) begin fails++; $display("FAIL reset_len got=%0d exp=0", len_out); end
        tests++; if (empty_out !== 1'b1 || full_out !== 1'b0) begin fails++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", empty_out, full_out); end
        tests++; if (data_out !== 8'h00 || data_valid_out !== 1'b0) begin fails++; $display("FAIL reset_data got=%h v=%b exp=00 v=0", data_out, data_valid_out); end
        tests++; if (EA_queue !== 1'b0) begin fails++; $display("FAIL reset_state got=%b exp=0", EA_queue); end
    endtask

    task automatic test_single_write();
        data_in    = 8'hA5;
        enqueue_in = 1'b1;
        tick();
        tests++; if (ack_out !== 1'b1 || len_out !== 4'd1) begin fails++; $display("FAIL sw_first got ack=%b len=%0d exp ack=1 len=1", ack_out, len_out); end
        tick();
        tick();
        tests++; if (ack_out !== 1'b1 || len_out !== 4'd1 || EA_queue !== 1'b1) begin fails++; $display("FAIL sw_hold got ack=%b len=%0d st=%b exp ack=1 len=1 st=1", ack_out, len_out, EA_queue); end
        enqueue_in = 1'b0;
        tick();
        tests++; if (ack_out !== 1'b0 || len_out !== 4'd1 || empty_out !== 1'b0) begin fails++; $display("FAIL sw_drop got ack=%b len=%0d e=%b exp ack=0 len=1 e=0", ack_out, len_out, empty_out); end
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        tests++; if (data_out !== 8'hA5 || data_valid_out !== 1'b1 || empty_out !== 1'b1) begin fails++; $display("FAIL sw_pop got=%h v=%b e=%b exp=a5 v=1 e=1", data_out, data_valid_out, empty_out); end
        tick();
        tests++; if (data_valid_out !== 1'b0) begin fails++; $display("FAIL sw_pulse got v=%b exp v=0", data_valid_out); end
    endtask

    task automatic test_full_backpressure();
        for (int i = 1; i <= 8; i++) handshake(8'(i));
        tests++; if (len_out !== 4'd8 || full_out !== 1'b1) begin fails++; $display("FAIL full_fill got len=%0d f=%b exp len=8 f=1", len_out, full_out); end
        data_in    = 8'h09;
        enqueue_in = 1'b1;
        tick();
        tick();
        tests++; if (ack_out !== 1'b0 || len_out !== 4'd8 || EA_queue !== 1'b0) begin fails++; $display("FAIL full_block got ack=%b len=%0d st=%b exp ack=0 len=8 st=0", ack_out, len_out, EA_queue); end
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        tests++; if (data_out !== 8'h01 || data_valid_out !== 1'b1 || len_out !== 4'd7 || ack_out !== 1'b0) begin fails++; $display("FAIL full_pop got=%h v=%b len=%0d ack=%b exp=01 v=1 len=7 ack=0", data_out, data_valid_out, len_out, ack_out); end
        tick();
        tests++; if (ack_out !== 1'b1 || len_out !== 4'd8 || full_out !== 1'b1) begin fails++; $display("FAIL full_accept got ack=%b len=%0d f=%b exp ack=1 len=8 f=1", ack_out, len_out, full_out); end
        enqueue_in = 1'b0;
        tick();
        tests++; if (ack_out !== 1'b0 || len_out !== 4'd8) begin fails++; $display("FAIL full_release got ack=%b len=%0d exp ack=0 len=8", ack_out, len_out); end
        dequeue_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (data_out !== 8'(2 + i) || data_valid_out !== 1'b1) begin fails++; $display("FAIL drain_%0d got=%h v=%b exp=%h v=1", i, data_out, data_valid_out, 8'(2 + i)); end
        end
        tests++; if (len_out !== 4'd0 || empty_out !== 1'b1) begin fails++; $display("FAIL drain_end got len=%0d e=%b exp len=0 e=1", len_out, empty_out); end
    endtask

    // Entered with dequeue_in still high and the queue just emptied.
    task automatic test_empty_dequeue();
        tick();
        tick();
        dequeue_in = 1'b0;
        tests++; if (data_valid_out !== 1'b0 || data_out !== 8'h09 || len_out !== 4'd0) begin fails++; $display("FAIL empty_pop got v=%b d=%h len=%0d exp v=0 d=09 len=0", data_valid_out, data_out, len_out); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) handshake(8'(8'h10 + i));
        tests++; if (full_out !== 1'b1) begin fails++; $display("FAIL wrap_full got f=%b exp f=1", full_out); end
        dequeue_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (data_out !== 8'(8'h10 + i) || data_valid_out !== 1'b1) begin fails++; $display("FAIL wrap_%0d got=%h v=%b exp=%h v=1", i, data_out, data_valid_out, 8'(8'h10 + i)); end
        end
        dequeue_in = 1'b0;
        tick();
        tests++; if (empty_out !== 1'b1 || data_valid_out !== 1'b0 || data_out !== 8'h17) begin fails++; $display("FAIL wrap_end got e=%b v=%b d=%h exp e=1 v=0 d=17", empty_out, data_valid_out, data_out); end
    endtask

    task automatic test_simultaneous();
        handshake(8'hAA);
        handshake(8'hBB);
        handshake(8'hCC);
        data_in    = 8'h55;
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick();
        tests++; if (len_out !== 4'd3 || data_out !== 8'hAA || ack_out !== 1'b1) begin fails++; $display("FAIL sim_both got len=%0d d=%h ack=%b exp len=3 d=aa ack=1", len_out, data_out, ack_out); end
        enqueue_in = 1'b0;
        tick();
        tests++; if (data_out !== 8'hBB || len_out !== 4'd2) begin fails++; $display("FAIL sim_pop2 got d=%h len=%0d exp d=bb len=2", data_out, len_out); end
        tick();
        tests++; if (data_out !== 8'hCC || len_out !== 4'd1) begin fails++; $display("FAIL sim_pop3 got d=%h len=%0d exp d=cc len=1", data_out, len_out); end
        tick();
        dequeue_in = 1'b0;
        tests++; if (data_out !== 8'h55 || len_out !== 4'd0 || empty_out !== 1'b1) begin fails++; $display("FAIL sim_pop4 got d=%h len=%0d e=%b exp d=55 len=0 e=1", data_out, len_out, empty_out); end
    endtask

    task automatic test_reset_mid_handshake();
        for (int i = 0; i < 4; i++) handshake(8'(8'h20 + i));
        data_in    = 8'h24;
        enqueue_in = 1'b1;
        tick();
        tests++; if (len_out !== 4'd5 || ack_out !== 1'b1) begin fails++; $display("FAIL rst_pre got len=%0d ack=%b exp len=5 ack=1", len_out, ack_out); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enqueue_in = 1'b0;
        tests++; if (ack_out !== 1'b0 || len_out !== 4'd0 || empty_out !== 1'b1 || EA_queue !== 1'b0) begin fails++; $display("FAIL rst_mid got ack=%b len=%0d e=%b st=%b exp ack=0 len=0 e=1 st=0", ack_out, len_out, empty_out, EA_queue); end
        tests++; if (data_out !== 8'h00 || full_out !== 1'b0) begin fails++; $display("FAIL rst_mid_data got d=%h f=%b exp d=00 f=0", data_out, full_out); end
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        tests++; if (data_valid_out !== 1'b0 || len_out !== 4'd0) begin fails++; $display("FAIL rst_discard got v=%b len=%0d exp v=0 len=0", data_valid_out, len_out); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_backpressure();
        test_empty_dequeue();
        test_wrap();
        test_simultaneous();
        test_reset_mid_handshake();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
